// File: rtl/if_id_pkg.sv
// Shared constants and types for the IF/ID instruction queue.
// Optional bubble counter is enabled with IF_ID_BUBBLE_CNT_EN.
package if_id_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_STEP   = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached, cleared only by reset.
module if_id_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_queue.sv
// Two-entry IF/ID instruction queue with flush. Define IF_ID_BUBBLE_CNT_EN to build
// the decode-starvation counter; otherwise bubble_count_o is tied to zero.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int unsigned        DATA_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_VALUE = DATA_W'(if_id_pkg::NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid_i,
  input  logic [DATA_W-1:0] fetch_instr_i,
  input  logic [DATA_W-1:0] fetch_pc_i,
  output logic              fetch_ready_o,
  input  logic              flush_i,
  output logic              dec_valid_o,
  output logic [DATA_W-1:0] dec_instr_o,
  output logic [DATA_W-1:0] dec_pc_o,
  output logic [DATA_W-1:0] dec_pc4_o,
  input  logic              dec_ready_i,
  output logic [1:0]        occupancy_o,
  output logic [31:0]       bubble_count_o
);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
  } entry_t;

  entry_t     slot0_q, slot0_d, slot1_q, slot1_d, in_entry;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign in_entry      = '{instr: fetch_instr_i, pc: fetch_pc_i};
  assign fetch_ready_o = (count_q != 2'd2);
  assign dec_valid_o   = (count_q != 2'd0);
  assign push          = fetch_valid_i & fetch_ready_o;
  assign pop           = dec_valid_o & dec_ready_i;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush_i) begin
      // Slot contents are left stale; outputs are masked while empty.
      count_d = 2'd0;
    end else begin
      unique case (count_q)
        2'd0: begin
          if (push) begin
            slot0_d = in_entry;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            slot0_d = in_entry;
          end else if (push) begin
            slot1_d = in_entry;
            count_d = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            slot0_d = slot1_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign dec_instr_o = dec_valid_o ? slot0_q.instr : NOP_VALUE;
  assign dec_pc_o    = dec_valid_o ? slot0_q.pc : '0;
  assign dec_pc4_o   = dec_pc_o + DATA_W'(PC_STEP);
  assign occupancy_o = count_q;

`ifdef IF_ID_BUBBLE_CNT_EN
  if_id_sat_counter #(
    .Width(32)
  ) u_bubble_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(dec_ready_i & ~dec_valid_o),
    .cnt_o(bubble_count_o)
  );
`else
  assign bubble_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus random traffic against a
// queue-based reference model; a negedge monitor compares DUT outputs with the model.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n;
  logic        fetch_valid_i;
  logic [31:0] fetch_instr_i;
  logic [31:0] fetch_pc_i;
  logic        fetch_ready_o;
  logic        flush_i;
  logic        dec_valid_o;
  logic [31:0] dec_instr_o;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_pc4_o;
  logic        dec_ready_i;
  logic [1:0]  occupancy_o;
  logic [31:0] bubble_count_o;

  if_id_queue dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_valid_i (fetch_valid_i),
    .fetch_instr_i (fetch_instr_i),
    .fetch_pc_i    (fetch_pc_i),
    .fetch_ready_o (fetch_ready_o),
    .flush_i       (flush_i),
    .dec_valid_o   (dec_valid_o),
    .dec_instr_o   (dec_instr_o),
    .dec_pc_o      (dec_pc_o),
    .dec_pc4_o     (dec_pc4_o),
    .dec_ready_i   (dec_ready_i),
    .occupancy_o   (occupancy_o),
    .bubble_count_o(bubble_count_o)
  );

  initial forever #5 clk = clk_en ? ~clk : clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];       // expected queue contents, head first
  logic [31:0] bub_exp;
  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;
  bit          last_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, then advance the reference model at the clock edge.
  task automatic cycle(input bit fv, input logic [31:0] ins, input logic [31:0] pc,
                       input bit dr, input bit fl);
    int sz;
    fetch_valid_i = fv;
    fetch_instr_i = ins;
    fetch_pc_i    = pc;
    dec_ready_i   = dr;
    flush_i       = fl;
    @(posedge clk);
    sz = mq.size();
`ifdef IF_ID_BUBBLE_CNT_EN
    if (dr && sz == 0 && bub_exp != 32'hFFFF_FFFF) bub_exp = bub_exp + 1;
`endif
    last_acc = fv && (sz != 2) && !fl;
    if (fl) begin
      mq.delete();
    end else begin
      if (dr && sz != 0) void'(mq.pop_front());
      if (fv && sz != 2) mq.push_back('{instr: ins, pc: pc});
    end
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dec_valid"},   {31'd0, dec_valid_o},   32'd0);
    check({tag, "_dec_instr"},   dec_instr_o,            32'h0);
    check({tag, "_dec_pc"},      dec_pc_o,               32'h0);
    check({tag, "_dec_pc4"},     dec_pc4_o,              32'd4);
    check({tag, "_occupancy"},   {30'd0, occupancy_o},   32'd0);
    check({tag, "_fetch_ready"}, {31'd0, fetch_ready_o}, 32'd1);
    check({tag, "_bubble"},      bubble_count_o,         32'd0);
  endtask

  // Monitor: compares DUT outputs against the model's view of the queue.
  logic [31:0] m_pc, m_instr;
  logic        m_v;
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      m_v     = (mq.size() != 0);
      m_instr = m_v ? mq[0].instr : 32'h0;
      m_pc    = m_v ? mq[0].pc : 32'h0;
      check("dec_valid",   {31'd0, dec_valid_o},   {31'd0, m_v});
      check("dec_instr",   dec_instr_o,            m_instr);
      check("dec_pc",      dec_pc_o,               m_pc);
      check("dec_pc4",     dec_pc4_o,              m_pc + 32'd4);
      check("occupancy",   {30'd0, occupancy_o},   mq.size());
      check("fetch_ready", {31'd0, fetch_ready_o}, {31'd0, mq.size() != 2});
      check("bubble",      bubble_count_o,         bub_exp);
    end
  end

  initial begin
    logic [31:0] p_instr, p_pc;
    bit          fv, dr, fl;
    rst_n         = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_instr_i = '0;
    fetch_pc_i    = '0;
    dec_ready_i   = 1'b0;
    flush_i       = 1'b0;
    bub_exp       = '0;
    #20;
    check_reset_values("reset");
    rst_n  = 1'b1;
    #3;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Bubbles on an empty queue.
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`ifdef IF_ID_BUBBLE_CNT_EN
    check("bubble_five", bubble_count_o, 32'd5);
`else
    check("bubble_off", bubble_count_o, 32'd0);
`endif

    // Streaming with decode always ready.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hA000_0000 + i, 32'(i * 4), 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure: fill, hold third, then drain.
    cycle(1'b1, 32'hB000_0010, 32'h10, 1'b0, 1'b0);
    cycle(1'b1, 32'hB000_0014, 32'h14, 1'b0, 1'b0);
    cycle(1'b1, 32'hB000_0018, 32'h18, 1'b0, 1'b0);
    check("bp_full_ready", {31'd0, fetch_ready_o}, 32'd0);
    cycle(1'b1, 32'hB000_0018, 32'h18, 1'b1, 1'b0);
    cycle(1'b1, 32'hB000_0018, 32'h18, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush while full with a simultaneous push.
    cycle(1'b1, 32'hC000_0020, 32'h20, 1'b0, 1'b0);
    cycle(1'b1, 32'hC000_0024, 32'h24, 1'b0, 1'b0);
    cycle(1'b1, 32'hC000_0028, 32'h28, 1'b0, 1'b1);
    check("flush_empty", {30'd0, occupancy_o}, 32'd0);
    cycle(1'b1, 32'hC000_0100, 32'h100, 1'b0, 1'b0);
    check("post_flush_pc", dec_pc_o, 32'h100);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // PC wrap.
    cycle(1'b1, 32'hD000_0000, 32'hFFFF_FFFC, 1'b0, 1'b0);
    check("wrap_pc4", dec_pc4_o, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

`ifdef IF_ID_BUBBLE_CNT_EN
    force dut.u_bubble_cnt.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_bubble_cnt.cnt_q;
    bub_exp = 32'hFFFF_FFFF;
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("bubble_sat", bubble_count_o, 32'hFFFF_FFFF);
`endif

    // Random traffic; fetch holds its data until accepted.
    p_instr = $urandom;
    p_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    for (int i = 0; i < 600; i++) begin
      fv = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 15) == 0);
      cycle(fv, p_instr, p_pc, dr, fl);
      if (last_acc || fl) begin
        p_instr = $urandom;
        p_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      end
    end

    // Asynchronous reset mid-operation, between clock edges.
    cycle(1'b1, 32'hE000_0000, 32'h200, 1'b0, 1'b0);
    cycle(1'b1, 32'hE000_0004, 32'h204, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    mq.delete();
    bub_exp = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 32'hE000_0008, 32'h208, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Two-entry instruction queue forming the IF/ID boundary of the pipelined processor. It accepts instruction/PC pairs from the fetch stage over a valid/ready handshake, buffers them so a decode stall does not force the fetch PC register to freeze in the same cycle, and presents the head entry to decode. A flush input discards all buffered instructions on a taken jump or branch.

## Interface

- DATA_W, 32, instruction and PC width
- NOP_INSTR, 32'h0000_0000, instruction value driven to decode when the queue is empty or flushed
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_valid  in  1  fetch presents a valid instruction
- fetch_instr  in  DATA_W  instruction word from instruction memory
- fetch_pc  in  DATA_W  address of fetch_instr
- fetch_ready  out  1  queue can accept this cycle
- flush  in  1  discard all entries (jump/branch taken)
- dec_valid  out  1  head entry valid
- dec_instr  out  DATA_W  head instruction (NOP_INSTR when not valid)
- dec_pc  out  DATA_W  head PC (0 when not valid)
- dec_pc4  out  DATA_W  dec_pc + 4 modulo 2^DATA_W (4 when not valid)
- dec_ready  in  1  decode consumes head this cycle
- occupancy  out  2  entries held (0..2)
- bubble_count  out  32  decode starvation counter (see Configuration)

## Operation

- Storage: slot0 (head), slot1; each holds {instr, pc}; count register 0..2.
- push = fetch_valid & fetch_ready; pop = dec_valid & dec_ready.
- fetch_ready = (count != 2); depends only on registered state, no combinational path from dec_ready or flush.
- dec_valid = (count != 0).
- count 0, push: slot0 <= input; count 1.
- count 1, push only: slot1 <= input; count 2.
- count 1, push & pop: slot0 <= input; count 1.
- count 1, pop only: count 0.
- count 2, pop: slot0 <= slot1; count 1 (push impossible, fetch_ready 0).
- flush has priority over push and pop: on the edge with flush=1, count <= 0; any simultaneous push is dropped and pop is irrelevant; slot contents need not be cleared but outputs show NOP_INSTR/0.
- dec_pc4 computed from dec_pc; carry out discarded (32'hFFFF_FFFC + 4 = 0).
- fetch_valid with fetch_ready=0: no state change; fetch must hold its data.

## Timing

- Reset (asynchronous assert, synchronous-to-clk deassert assumed upstream): count 0, dec_valid 0, dec_instr NOP_INSTR, dec_pc 0, dec_pc4 4, occupancy 0, fetch_ready 1, bubble_count 0.
- Latency: instruction pushed at edge N is on dec_* from edge N until popped; one cycle fetch-to-decode.
- Throughput: one instruction per cycle sustained when dec_ready held 1.
- After flush at edge N: dec_valid 0 and fetch_ready 1 in cycle following N; the first post-flush push may occur at edge N+1.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of clk.

## Configuration

- IF_ID_BUBBLE_CNT_EN defined: bubble_count increments by 1 on every rising edge where dec_ready=1 and dec_valid=0; saturates at 32'hFFFF_FFFF; cleared only by rst_n.
- Undefined: counter logic not built; bubble_count tied to 0.

## Structure

- Package if_id_pkg: NOP_INSTR constant, typedef if_id_entry_t {instr, pc}, constant PC_STEP = 4.
- Optional sub-module if_id_sat_counter (32-bit saturating incrementer), instantiated only under IF_ID_BUBBLE_CNT_EN.

## Test plan

- Reset: rst_n low with clk stopped -> dec_valid 0, dec_instr 32'h0, dec_pc4 4, fetch_ready 1, occupancy 0.
- Streaming: push pc 0x00,0x04,0x08 with dec_ready=1 -> dec_pc 0x00,0x04,0x08 on consecutive cycles, occupancy stays 1, fetch_ready stays 1.
- Backpressure: dec_ready=0, push 0x10,0x14,0x18 -> occupancy 2, fetch_ready 0, 0x18 held by fetch; release dec_ready -> 0x10,0x14,0x18 emerge in order, no loss or duplication.
- Flush: queue full (0x20,0x24), flush=1 with fetch_valid=1 pc 0x28 -> next cycle dec_valid 0, occupancy 0, 0x28 never appears; following push 0x100 appears next cycle.
- Wrap: push pc 32'hFFFF_FFFC -> dec_pc4 = 32'h0000_0000.
- Counter (macro on): 5 cycles dec_ready=1 with empty queue -> bubble_count 5; force counter to 32'hFFFF_FFFF, one more bubble -> stays 32'hFFFF_FFFF; macro off -> always 0.
